// File: rtl/common_defs.sv
// Shared encodings for the wave dispatcher: global FSM states, per-SIMD slot
// states and the default wave width.
package common_defs;

  localparam int DEFAULT_WAVE_SIZE = 32;

  typedef enum logic [2:0] {
    DISP_IDLE,
    DISP_CALC,
    DISP_DISPATCH,
    DISP_DRAIN,
    DISP_DONE
  } disp_state_t;

  typedef enum logic [1:0] {
    SLOT_READY,
    SLOT_START,
    SLOT_WORKING
  } slot_state_t;

endpackage

// File: rtl/simd_slot.sv
// One SIMD handshake slot: READY -> START (one-cycle start pulse) -> WORKING,
// and back to READY when the SIMD reports its wave finished.
module simd_slot
  import common_defs::*;
#(
  parameter int WAVE_ID_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_enable,
  input  logic                     i_issue,
  input  logic [WAVE_ID_WIDTH-1:0] i_wave_id,
  input  logic                     i_simd_done,
  output logic                     o_ready,
  output logic                     o_start,
  output logic                     o_working,
  output logic [WAVE_ID_WIDTH-1:0] o_wave_id
);

  slot_state_t              r_state;
  logic                     r_ready;
  logic                     r_start;
  logic                     r_working;
  logic [WAVE_ID_WIDTH-1:0] r_wave_id;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= SLOT_READY;
      r_ready   <= 1'b1;
      r_start   <= 1'b0;
      r_working <= 1'b0;
      r_wave_id <= '0;
    end else if (!i_enable) begin
      // Frozen: hold state, but never stretch the start pulse.
      r_start <= 1'b0;
    end else begin
      case (r_state)
        SLOT_READY: begin
          if (i_issue) begin
            r_state   <= SLOT_START;
            r_wave_id <= i_wave_id;
            r_start   <= 1'b1;
            r_ready   <= 1'b0;
          end
        end
        SLOT_START: begin
          r_state   <= SLOT_WORKING;
          r_start   <= 1'b0;
          r_working <= 1'b1;
        end
        SLOT_WORKING: begin
          if (i_simd_done) begin
            r_state   <= SLOT_READY;
            r_working <= 1'b0;
            r_ready   <= 1'b1;
          end
        end
        default: begin
          r_state   <= SLOT_READY;
          r_start   <= 1'b0;
          r_working <= 1'b0;
          r_ready   <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready   = r_ready;
  assign o_start   = r_start;
  assign o_working = r_working;
  assign o_wave_id = r_wave_id;

endmodule

// File: rtl/wave_dispatcher.sv
// Splits one thread block into waves and issues them round-robin onto the
// SIMD slots, pulsing block_done once every issued wave has returned.
module wave_dispatcher
  import common_defs::*;
#(
  parameter int NUM_SIMD      = 2,
  parameter int WAVE_SIZE     = DEFAULT_WAVE_SIZE,
  parameter int WAVE_ID_WIDTH = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    enable,
  input  logic                                    block_start,
  input  logic signed [31:0]                      block_id,
  input  logic        [31:0]                      block_dim,
  input  logic        [31:0]                      num_threads,
  output logic                                    block_busy,
  output logic                                    block_done,
  output logic        [WAVE_ID_WIDTH-1:0]         num_waves_in_block,
  output logic        [NUM_SIMD-1:0]              simd_ready,
  output logic        [NUM_SIMD-1:0]              simd_start,
  output logic        [NUM_SIMD-1:0]              simd_working,
  output logic        [NUM_SIMD-1:0][WAVE_ID_WIDTH-1:0] simd_wave_id,
  input  logic        [NUM_SIMD-1:0]              simd_done
);

  localparam int WAVE_SHIFT = $clog2(WAVE_SIZE);
  localparam int PTR_W      = (NUM_SIMD > 1) ? $clog2(NUM_SIMD) : 1;

  disp_state_t              r_state;
  logic signed [31:0]       r_block_id;
  logic [31:0]              r_block_dim;
  logic [31:0]              r_num_threads;
  logic [WAVE_ID_WIDTH-1:0] r_num_waves;
  logic [WAVE_ID_WIDTH-1:0] r_next_wave;
  logic [PTR_W-1:0]         r_rr_ptr;
  logic                     r_block_done;

  logic signed [63:0]       w_threads;
  logic signed [63:0]       w_id;
  logic signed [63:0]       w_dim;
  logic signed [63:0]       w_rem;
  logic signed [63:0]       w_t;
  logic [WAVE_ID_WIDTH-1:0] w_calc_waves;
  logic [WAVE_ID_WIDTH-1:0] w_next_wave_inc;
  logic [NUM_SIMD-1:0]      w_ready;
  logic [NUM_SIMD-1:0]      w_issue_vec;
  logic [PTR_W-1:0]         w_pick;
  logic [PTR_W-1:0]         w_next_rr;
  logic                     w_found;
  logic                     w_issue;

  // Threads left for this block, clamped to [0, block_dim], in 64-bit signed
  // so a large block_id*block_dim cannot wrap.
  assign w_threads    = {32'b0, r_num_threads};
  assign w_id         = {{32{r_block_id[31]}}, r_block_id};
  assign w_dim        = {32'b0, r_block_dim};
  assign w_rem        = w_threads - w_id * w_dim;
  assign w_t          = (w_rem <= 0) ? '0 : ((w_rem < w_dim) ? w_rem : w_dim);
  assign w_calc_waves = WAVE_ID_WIDTH'((w_t + 64'(WAVE_SIZE - 1)) >> WAVE_SHIFT);

  assign w_next_wave_inc = r_next_wave + 1'b1;

  // NOTE: every combinational output gets a default before the loop so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < NUM_SIMD; i++) begin
      if (!w_found && w_ready[(int'(r_rr_ptr) + i) % NUM_SIMD]) begin
        w_found = 1'b1;
        w_pick  = PTR_W'((int'(r_rr_ptr) + i) % NUM_SIMD);
      end
    end
  end

  assign w_next_rr = PTR_W'((int'(w_pick) + 1) % NUM_SIMD);
  assign w_issue   = enable && (r_state == DISP_DISPATCH) &&
                     (r_next_wave < r_num_waves) && w_found;

  always_comb begin
    w_issue_vec = '0;
    if (w_issue) w_issue_vec[w_pick] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= DISP_IDLE;
      r_block_id    <= '0;
      r_block_dim   <= '0;
      r_num_threads <= '0;
      r_num_waves   <= '0;
      r_next_wave   <= '0;
      r_rr_ptr      <= '0;
      r_block_done  <= 1'b0;
    end else if (!enable) begin
      r_block_done <= 1'b0;
    end else begin
      r_block_done <= 1'b0;
      case (r_state)
        DISP_IDLE: begin
          if (block_start) begin
            r_block_id    <= block_id;
            r_block_dim   <= block_dim;
            r_num_threads <= num_threads;
            r_state       <= DISP_CALC;
          end
        end
        DISP_CALC: begin
          r_num_waves <= w_calc_waves;
          r_state     <= (w_calc_waves == '0) ? DISP_DONE : DISP_DISPATCH;
        end
        DISP_DISPATCH: begin
          if (w_issue) begin
            r_next_wave <= w_next_wave_inc;
            r_rr_ptr    <= w_next_rr;
            if (w_next_wave_inc >= r_num_waves) r_state <= DISP_DRAIN;
          end else if (r_next_wave >= r_num_waves) begin
            r_state <= DISP_DRAIN;
          end
        end
        DISP_DRAIN: begin
          // A slot freed this edge is only seen as READY next cycle, so a
          // just-accepted simd_done is never still outstanding here.
          if (&w_ready) r_state <= DISP_DONE;
        end
        DISP_DONE: begin
          r_block_done <= 1'b1;
          r_next_wave  <= '0;
          r_state      <= DISP_IDLE;
        end
        default: r_state <= DISP_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_SIMD; g++) begin : g_slot
    simd_slot #(
      .WAVE_ID_WIDTH(WAVE_ID_WIDTH)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .i_enable   (enable),
      .i_issue    (w_issue_vec[g]),
      .i_wave_id  (r_next_wave),
      .i_simd_done(simd_done[g]),
      .o_ready    (w_ready[g]),
      .o_start    (simd_start[g]),
      .o_working  (simd_working[g]),
      .o_wave_id  (simd_wave_id[g])
    );
  end

  assign simd_ready         = w_ready;
  assign block_busy         = (r_state != DISP_IDLE);
  assign block_done         = r_block_done;
  assign num_waves_in_block = r_num_waves;

endmodule

// File: tb/tb_wave_dispatcher.sv
// Bench for wave_dispatcher: expected wave issues (SIMD, wave_id, cycle) are
// queued when a block is launched and matched as simd_start pulses appear.
module tb_wave_dispatcher;

  typedef struct {
    int simd;
    int wave;
    int cyc;
  } issue_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic               block_start;
  logic signed [31:0] block_id;
  logic [31:0]        block_dim;
  logic [31:0]        num_threads;
  logic               block_busy;
  logic               block_done;
  logic [31:0]        num_waves_in_block;
  logic [1:0]         simd_ready;
  logic [1:0]         simd_start;
  logic [1:0]         simd_working;
  logic [1:0][31:0]   simd_wave_id;
  logic [1:0]         simd_done;

  issue_t q[$];
  int     cyc      = 0;
  int     errors   = 0;
  int     checks   = 0;
  int     done_cnt = 0;
  int     done_cyc = -1;

  wave_dispatcher #(
    .NUM_SIMD     (2),
    .WAVE_SIZE    (32),
    .WAVE_ID_WIDTH(32)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .block_start       (block_start),
    .block_id          (block_id),
    .block_dim         (block_dim),
    .num_threads       (num_threads),
    .block_busy        (block_busy),
    .block_done        (block_done),
    .num_waves_in_block(num_waves_in_block),
    .simd_ready        (simd_ready),
    .simd_start        (simd_start),
    .simd_working      (simd_working),
    .simd_wave_id      (simd_wave_id),
    .simd_done         (simd_done)
  );

  always #5 clk = ~clk;

  // Advance one clock, sample 1 time unit after the edge, score start pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (simd_start[i] === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start simd=%0d wave=%0d cyc=%0d", i, simd_wave_id[i], cyc);
        end else begin
          issue_t e;
          e = q.pop_front();
          if (e.simd !== i || e.wave !== int'(simd_wave_id[i]) || e.cyc !== cyc) begin
            errors++;
            $display("FAIL issue got simd=%0d wave=%0d cyc=%0d want simd=%0d wave=%0d cyc=%0d",
                     i, simd_wave_id[i], cyc, e.simd, e.wave, e.cyc);
          end
        end
      end
    end
    if (block_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic push(input int simd, input int wave, input int at);
    issue_t e;
    e.simd = simd;
    e.wave = wave;
    e.cyc  = at;
    q.push_back(e);
  endtask

  task automatic start_block(input int id, input int dim, input int thr, output int c0);
    block_id    = id;
    block_dim   = dim;
    num_threads = thr;
    block_start = 1'b1;
    tick();
    c0          = cyc;
    block_start = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b0;
    enable      = 1'b1;
    block_start = 1'b0;
    block_id    = '0;
    block_dim   = '0;
    num_threads = '0;
    simd_done   = '0;
    tick();
    tick();
    checks++;
    if ({block_busy, block_done, simd_ready, simd_start, simd_working} !== 8'b0_0_11_00_00) begin
      errors++;
      $display("FAIL reset_ctrl got busy=%b done=%b rdy=%b st=%b wk=%b want 0 0 11 00 00",
               block_busy, block_done, simd_ready, simd_start, simd_working);
    end
    checks++;
    if (num_waves_in_block !== 32'd0 || simd_wave_id !== 64'd0) begin
      errors++;
      $display("FAIL reset_data got nw=%0d ids=%h want 0 0", num_waves_in_block, simd_wave_id);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_full_block();
    int c0;
    int d0;
    d0 = done_cnt;
    start_block(0, 64, 64, c0);
    push(0, 0, c0 + 2);
    push(1, 1, c0 + 3);
    for (int k = 1; k <= 9; k++) begin
      tick();
      simd_done = (k == 4) ? 2'b01 : (k == 5) ? 2'b10 : 2'b00;
      if (k == 1) begin
        checks++;
        if (num_waves_in_block !== 32'd2 || block_busy !== 1'b1) begin
          errors++;
          $display("FAIL full_calc got nw=%0d busy=%b want 2 1", num_waves_in_block, block_busy);
        end
      end
      if (k == 4) begin
        checks++;
        if (simd_working !== 2'b11 || simd_ready !== 2'b00) begin
          errors++;
          $display("FAIL full_working got wk=%b rdy=%b want 11 00", simd_working, simd_ready);
        end
      end
    end
    checks++;
    if (done_cnt - d0 !== 1 || done_cyc !== c0 + 8) begin
      errors++;
      $display("FAIL full_done got pulses=%0d at=%0d want 1 at=%0d", done_cnt - d0, done_cyc, c0 + 8);
    end
    checks++;
    if (block_busy !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL full_idle got busy=%b pending=%0d want 0 0", block_busy, q.size());
    end
  endtask

  task automatic test_tail_block();
    int c0;
    int d0;
    d0 = done_cnt;
    start_block(1, 64, 80, c0);
    push(0, 0, c0 + 2);
    for (int k = 1; k <= 7; k++) begin
      tick();
      simd_done = (k == 3) ? 2'b01 : 2'b00;
      if (k == 1) begin
        checks++;
        if (num_waves_in_block !== 32'd1) begin
          errors++;
          $display("FAIL tail_calc got nw=%0d want 1", num_waves_in_block);
        end
      end
      if (k == 3) begin
        checks++;
        if (simd_ready !== 2'b10 || simd_working !== 2'b01) begin
          errors++;
          $display("FAIL tail_slots got rdy=%b wk=%b want 10 01", simd_ready, simd_working);
        end
      end
    end
    checks++;
    if (done_cnt - d0 !== 1 || done_cyc !== c0 + 6 || q.size() != 0) begin
      errors++;
      $display("FAIL tail_done got pulses=%0d at=%0d pending=%0d want 1 at=%0d 0",
               done_cnt - d0, done_cyc, q.size(), c0 + 6);
    end
  endtask

  task automatic test_empty_block();
    int c0;
    int d0;
    d0 = done_cnt;
    start_block(2, 64, 80, c0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 1) begin
        checks++;
        if (num_waves_in_block !== 32'd0 || block_busy !== 1'b1) begin
          errors++;
          $display("FAIL empty_calc got nw=%0d busy=%b want 0 1", num_waves_in_block, block_busy);
        end
      end
    end
    checks++;
    if (done_cnt - d0 !== 1 || done_cyc !== c0 + 2) begin
      errors++;
      $display("FAIL empty_done got pulses=%0d at=%0d want 1 at=%0d", done_cnt - d0, done_cyc, c0 + 2);
    end
  endtask

  task automatic test_reset_mid_dispatch();
    int c0;
    start_block(0, 160, 160, c0);
    push(1, 0, c0 + 2);
    push(0, 1, c0 + 3);
    for (int k = 1; k <= 3; k++) tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL mid_issues got pending=%0d want 0", q.size());
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({block_busy, block_done, simd_ready, simd_start, simd_working} !== 8'b0_0_11_00_00 ||
        num_waves_in_block !== 32'd0 || simd_wave_id !== 64'd0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b rdy=%b st=%b wk=%b nw=%0d ids=%h want 0 11 00 00 0 0",
               block_busy, simd_ready, simd_start, simd_working, num_waves_in_block, simd_wave_id);
    end
    #1;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (block_busy !== 1'b0 || simd_ready !== 2'b11) begin
      errors++;
      $display("FAIL mid_after got busy=%b rdy=%b want 0 11", block_busy, simd_ready);
    end
  endtask

  task automatic test_oversubscription();
    int          c0;
    int          d0;
    int          dk[5] = '{4, 6, 8, 9, 11};
    logic [1:0]  dm[5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    d0 = done_cnt;
    start_block(0, 160, 160, c0);
    push(0, 0, c0 + 2);
    push(1, 1, c0 + 3);
    push(0, 2, c0 + 6);
    push(1, 3, c0 + 8);
    push(0, 4, c0 + 10);
    for (int k = 1; k <= 15; k++) begin
      tick();
      simd_done = 2'b00;
      for (int j = 0; j < 5; j++) if (dk[j] == k) simd_done = dm[j];
      if (k == 1) begin
        checks++;
        if (num_waves_in_block !== 32'd5) begin
          errors++;
          $display("FAIL over_calc got nw=%0d want 5", num_waves_in_block);
        end
      end
    end
    checks++;
    if (done_cnt - d0 !== 1 || done_cyc !== c0 + 14 || q.size() != 0) begin
      errors++;
      $display("FAIL over_done got pulses=%0d at=%0d pending=%0d want 1 at=%0d 0",
               done_cnt - d0, done_cyc, q.size(), c0 + 14);
    end
  endtask

  task automatic test_freeze_and_ignore();
    int c0;
    int d0;
    d0 = done_cnt;
    start_block(0, 64, 64, c0);
    push(1, 0, c0 + 2);
    push(0, 1, c0 + 3);
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 2) begin
        block_dim   = 320;
        num_threads = 320;
        block_start = 1'b1;
        simd_done   = 2'b11;
      end
      if (k == 3) begin
        block_start = 1'b0;
        simd_done   = 2'b00;
      end
      if (k >= 4 && k <= 9) begin
        checks++;
        if (simd_working !== 2'b11 || simd_ready !== 2'b00 || block_busy !== 1'b1 ||
            num_waves_in_block !== 32'd2 || simd_wave_id[0] !== 32'd1 || simd_wave_id[1] !== 32'd0) begin
          errors++;
          $display("FAIL freeze_hold k=%0d got wk=%b rdy=%b busy=%b nw=%0d ids=%h",
                   k, simd_working, simd_ready, block_busy, num_waves_in_block, simd_wave_id);
        end
      end
      if (k == 4) enable = 1'b0;
      if (k == 6) simd_done = 2'b11;
      if (k == 9) enable = 1'b1;
      if (k == 10) begin
        checks++;
        if (simd_ready !== 2'b11 || simd_working !== 2'b00) begin
          errors++;
          $display("FAIL freeze_resume got rdy=%b wk=%b want 11 00", simd_ready, simd_working);
        end
        simd_done = 2'b00;
      end
    end
    checks++;
    if (done_cnt - d0 !== 1 || done_cyc !== c0 + 12 || q.size() != 0) begin
      errors++;
      $display("FAIL freeze_done got pulses=%0d at=%0d pending=%0d want 1 at=%0d 0",
               done_cnt - d0, done_cyc, q.size(), c0 + 12);
    end
    checks++;
    if (num_waves_in_block !== 32'd2 || block_busy !== 1'b0) begin
      errors++;
      $display("FAIL freeze_idle got nw=%0d busy=%b want 2 0", num_waves_in_block, block_busy);
    end
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_tail_block();
    test_empty_block();
    test_reset_mid_dispatch();
    test_oversubscription();
    test_freeze_and_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
